// File: rtl/key_regs_pkg.sv
// Shared constants for the key event front end:
// command codes, fixed response bytes and event layout.
package key_regs_pkg;

    localparam logic [7:0] CMD_POP     = 8'h80;
    localparam logic [7:0] CMD_STATUS  = 8'h81;
    localparam logic [7:0] CMD_ID      = 8'h82;

    localparam logic [7:0] ID_VALUE    = 8'hA5;
    localparam logic [7:0] EMPTY_EVENT = 8'hFF;

    localparam int EVT_PRESS_BIT = 7;
    localparam int EVT_IDX_MSB   = 6;

endpackage

// File: rtl/key_event_fifo.sv
// Event FIFO with first-word-fall-through head; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module key_event_fifo
    import key_regs_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic [W-1:0]  o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rp];

    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/key_event_spi_regs.sv
// Key debouncer, change scanner and event FIFO behind a byte-wide
// command interface fed by the SPI slave.
module key_event_spi_regs
    import key_regs_pkg::*;
#(
    parameter int NUM_KEYS       = 61,
    parameter int TICK_DIV       = 470,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_byte_i,
    output logic [7:0]          tx_byte_o,
    output logic                irq_o,
    output logic                keys_valid_o
);

    localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int PW  = $clog2(TICK_DIV);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] GROUPS_B = 8'((NUM_KEYS + 7) / 8);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [CW-1:0]       r_cnt [NUM_KEYS];
    logic [PW-1:0]       r_pre;
    logic [CW-1:0]       r_tcnt;
    logic                r_valid;
    logic [127:0]        r_rep;
    logic [6:0]          r_idx;
    logic                r_stall;
    logic [7:0]          r_tx;

    logic                w_tick;
    logic [127:0]        w_stable_pad;
    logic                w_sk;
    logic                w_diff;
    logic                w_full;
    logic                w_empty;
    logic [FCW-1:0]      w_count;
    logic [7:0]          w_head;
    logic [7:0]          w_evt;
    logic                w_pop;
    logic                w_push;
    logic                w_stall;
    logic                w_status_rd;
    logic [7:0]          w_rsp;

    assign w_tick       = (r_pre == PW'(TICK_DIV - 1));
    assign w_stable_pad = 128'(r_stable);
    assign w_sk         = w_stable_pad[r_idx];
    assign w_diff       = (w_sk != r_rep[r_idx]);
    assign w_pop        = rx_valid_i && (rx_byte_i == CMD_POP) && !w_empty;
    assign w_push       = w_diff && (!w_full || w_pop);
    assign w_stall      = w_diff && w_full && !w_pop;
    assign w_status_rd  = rx_valid_i && (rx_byte_i == CMD_STATUS);

    always_comb begin
        w_evt = '0;
        w_evt[EVT_PRESS_BIT] = w_sk;
        w_evt[EVT_IDX_MSB:0] = r_idx;
    end

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int k = 0; k < NUM_KEYS; k++) r_cnt[k] <= '0;
        end else begin
            r_sync1 <= keys_i;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (r_sync2[k] == r_stable[k]) begin
                        r_cnt[k] <= '0;
                    end else if (CW'(r_cnt[k] + 1'b1) == CW'(DEBOUNCE_TICKS)) begin
                        r_stable[k] <= ~r_stable[k];
                        r_cnt[k]    <= '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            r_pre   <= '0;
            r_tcnt  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick && !r_valid) begin
                if (r_tcnt == CW'(DEBOUNCE_TICKS - 1)) r_valid <= 1'b1;
                else r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    // A stalled scanner parks on the pending key so no change is skipped.
    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            r_rep   <= '0;
            r_idx   <= '0;
            r_stall <= 1'b0;
        end else begin
            if (!w_stall) begin
                if (w_push) r_rep[r_idx] <= w_sk;
                r_idx <= (r_idx == 7'(NUM_KEYS - 1)) ? '0 : r_idx + 7'd1;
            end
            if (w_stall) r_stall <= 1'b1;
            else if (w_status_rd) r_stall <= 1'b0;
        end
    end

    always_comb begin
        w_rsp = 8'h00;
        unique case (1'b1)
            (rx_byte_i < GROUPS_B):
                w_rsp = w_stable_pad[{rx_byte_i[3:0], 3'b000} +: 8];
            (rx_byte_i == CMD_POP):
                w_rsp = w_empty ? EMPTY_EVENT : w_head;
            (rx_byte_i == CMD_STATUS):
                w_rsp = {r_stall, r_valid, 6'(w_count)};
            (rx_byte_i == CMD_ID):
                w_rsp = ID_VALUE;
            default:
                w_rsp = 8'h00;
        endcase
    end

    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) r_tx <= '0;
        else if (rx_valid_i) r_tx <= w_rsp;
    end

    key_event_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk     (clk_g_i),
        .rst_n   (rstn_g_i),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign tx_byte_o    = r_tx;
    assign irq_o        = (w_count != '0);
    assign keys_valid_o = r_valid;

endmodule

// File: tb/tb_key_event_spi_regs.sv
// Directed bench for key_event_spi_regs: command table plus
// hand-written debounce, stall and reset sequences.
module tb_key_event_spi_regs;

    logic        clk;
    logic        rstn;
    logic [60:0] keys;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        irq;
    logic        kvalid;

    int total;
    int bad;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    vec_t tbl [8];

    key_event_spi_regs #(
        .NUM_KEYS       (61),
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk_g_i      (clk),
        .rstn_g_i     (rstn),
        .keys_i       (keys),
        .rx_valid_i   (rx_valid),
        .rx_byte_i    (rx_byte),
        .tx_byte_o    (tx_byte),
        .irq_o        (irq),
        .keys_valid_o (kvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%02h want=%02h", nm, act, exp);
        end
    endtask

    task automatic cmd(input logic [7:0] c, output logic [7:0] r);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = c;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        r = tx_byte;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        keys     = '0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        total    = 0;
        bad      = 0;
        rstn     = 1'b0;
        keys     = '0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;

        tbl[0] = '{8'h82, 8'hA5, "id"};
        tbl[1] = '{8'h81, 8'h40, "status_idle"};
        tbl[2] = '{8'h80, 8'hFF, "pop_empty"};
        tbl[3] = '{8'h00, 8'h00, "grp0_idle"};
        tbl[4] = '{8'h07, 8'h00, "grp7_idle"};
        tbl[5] = '{8'h08, 8'h00, "grp8_invalid"};
        tbl[6] = '{8'h55, 8'h00, "cmd_other"};
        tbl[7] = '{8'h83, 8'h00, "cmd_83"};

        // reset state and keys_valid boundary
        #2;
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_valid", {7'd0, kvalid}, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        repeat (11) @(posedge clk);
        #1 chk("valid_tick11", {7'd0, kvalid}, 8'h00);
        @(posedge clk);
        #1 chk("valid_tick12", {7'd0, kvalid}, 8'h01);

        for (int i = 0; i < 8; i++) begin
            cmd(tbl[i].cmd, r);
            chk(tbl[i].nm, r, tbl[i].exp);
        end
        cmd(8'h82, r);
        repeat (5) @(negedge clk);
        chk("tx_hold", tx_byte, 8'hA5);

        // single press of key 9
        do_reset();
        keys[9] = 1'b1;
        repeat (100) @(negedge clk);
        cmd(8'h01, r);
        chk("k9_grp1", r, 8'h02);
        chk("k9_irq", {7'd0, irq}, 8'h01);
        cmd(8'h80, r);
        chk("k9_pop", r, 8'h89);
        cmd(8'h80, r);
        chk("k9_pop_empty", r, 8'hFF);
        chk("k9_irq_low", {7'd0, irq}, 8'h00);

        // bounce on key 5 never settles for 3 ticks
        do_reset();
        for (int t = 0; t < 10; t++) begin
            keys[5] = ~keys[5];
            repeat (8) @(negedge clk);
        end
        repeat (100) @(negedge clk);
        chk("bounce_irq", {7'd0, irq}, 8'h00);
        cmd(8'h00, r);
        chk("bounce_grp0", r, 8'h00);
        cmd(8'h81, r);
        chk("bounce_status", r, 8'h40);

        // overflow: keys 0..9 pressed in turn with no pops
        do_reset();
        for (int k = 0; k < 10; k++) begin
            keys[k] = 1'b1;
            repeat (90) @(negedge clk);
        end
        cmd(8'h81, r);
        chk("stall_status", r, 8'hC8);
        for (int k = 0; k < 10; k++) begin
            cmd(8'h80, r);
            chk($sformatf("stall_pop%0d", k), r, 8'h80 + 8'(k));
            repeat (2) @(negedge clk);
        end
        cmd(8'h80, r);
        chk("stall_pop_empty", r, 8'hFF);
        cmd(8'h81, r);
        chk("stall_status_lo", r & 8'h7F, 8'h40);
        cmd(8'h81, r);
        chk("stall_status_final", r, 8'h40);

        // last key and padding bits
        do_reset();
        keys[60] = 1'b1;
        repeat (100) @(negedge clk);
        cmd(8'h07, r);
        chk("k60_grp7", r, 8'h10);
        cmd(8'h08, r);
        chk("k60_grp8", r, 8'h00);
        cmd(8'h80, r);
        chk("k60_pop", r, 8'hBC);

        // asynchronous reset with events queued
        do_reset();
        keys[2:0] = 3'b111;
        repeat (100) @(negedge clk);
        cmd(8'h81, r);
        chk("rstq_status", r, 8'h43);
        cmd(8'h82, r);
        #2;
        rstn = 1'b0;
        #1;
        chk("rstq_tx", tx_byte, 8'h00);
        chk("rstq_irq", {7'd0, irq}, 8'h00);
        chk("rstq_valid", {7'd0, kvalid}, 8'h00);
        keys = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        cmd(8'h81, r);
        chk("rstq_status_after", r, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
